// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: N-to-1 CBus arbiter with zero added latency.
// Selects one of NUM_INPUTS request ports and forwards it to the single
// downstream CBus port. Priority is rotating or fixed, selected by parameter.
// Once a multi-beat transaction starts, the grant is held until oresp.last.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous reset, active low
//   ireqs      upstream requests, one per input
//   iresps     upstream responses; only the granted input sees oresp
//   oreq       downstream request
//   oresp      downstream response (ready, last, data)
//   busy       a transaction is locked to grant_idx
//   grant_idx  input currently driving oreq (meaningful when oreq.valid)
//   proto_err  sticky; granted input dropped valid before last

package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [7:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

// state | meaning
// IDLE  | no transaction locked; grant is combinational from the scan
// BUSY  | transaction locked to lock_idx until oresp.last
module cbus_rr_arbiter #(
    parameter int NUM_INPUTS  = 2,
    parameter int ROUND_ROBIN = 1,
    localparam int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  cbus_pkg::cbus_req_t  ireqs  [NUM_INPUTS],
    output cbus_pkg::cbus_resp_t iresps [NUM_INPUTS],
    output cbus_pkg::cbus_req_t  oreq,
    input  cbus_pkg::cbus_resp_t oresp,
    output logic                 busy,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 proto_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   lock_idx;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   cur_idx;
    logic               any_valid;

    // Wrap explicitly so non-power-of-two input counts rotate correctly.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NUM_INPUTS - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // Scan from rr_ptr upward with wrap. Iterating in reverse scan order lets
    // the earliest valid index in scan order be the final assignment.
    always_comb begin
        int j;
        sel       = rr_ptr;
        any_valid = 1'b0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_INPUTS) begin
                j = j - NUM_INPUTS;
            end
            if (ireqs[j].valid) begin
                sel       = IDX_W'(j);
                any_valid = 1'b1;
            end
        end
    end

    assign cur_idx   = (state == BUSY) ? lock_idx : sel;
    assign grant_idx = cur_idx;
    assign busy      = (state == BUSY);

    // In BUSY the locked input is passed through even with valid low, so a
    // protocol violation is visible downstream as oreq.valid = 0.
    always_comb begin
        oreq = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            iresps[i] = '0;
        end
        if (state == BUSY || any_valid) begin
            oreq            = ireqs[cur_idx];
            iresps[cur_idx] = oresp;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            lock_idx  <= '0;
            rr_ptr    <= '0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        if (oresp.last) begin
                            if (ROUND_ROBIN != 0) begin
                                rr_ptr <= next_ptr(sel);
                            end
                        end else begin
                            state    <= BUSY;
                            lock_idx <= sel;
                        end
                    end
                end
                BUSY: begin
                    if (oresp.last) begin
                        state <= IDLE;
                        if (ROUND_ROBIN != 0) begin
                            rr_ptr <= next_ptr(lock_idx);
                        end
                    end else if (!ireqs[lock_idx].valid) begin
                        proto_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
module tb_cbus_rr_arbiter;
    import cbus_pkg::*;

    typedef struct packed {
        logic                  busy;
        logic                  err;
        logic                  gvalid;
        logic [1:0]            gidx;
        cbus_req_t             oreq;
        cbus_resp_t [3:0]      iresps;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    cbus_req_t  ireqs_a [4];
    cbus_req_t  ireqs_b [3];
    cbus_resp_t oresp = '0;

    cbus_resp_t iresps_a [4];
    cbus_resp_t iresps_b [3];
    cbus_req_t  oreq_a, oreq_b;
    logic       busy_a, busy_b, err_a, err_b;
    logic [1:0] gidx_a, gidx_b;

    // stimulus staging, applied together by tick()
    cbus_req_t  stim_req [4];
    cbus_resp_t stim_resp;
    logic       stim_rst;

    // reference model state: [0] = 4-input round robin, [1] = 3-input fixed
    int m_busy [2];
    int m_owner [2];
    int m_ptr [2];
    int m_err [2];

    exp_t q_a[$];
    exp_t q_b[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ireqs_b[0] = ireqs_a[0];
    assign ireqs_b[1] = ireqs_a[1];
    assign ireqs_b[2] = ireqs_a[2];

    cbus_rr_arbiter #(.NUM_INPUTS(4), .ROUND_ROBIN(1)) dut_a (
        .clk(clk), .reset(reset), .ireqs(ireqs_a), .iresps(iresps_a),
        .oreq(oreq_a), .oresp(oresp), .busy(busy_a), .grant_idx(gidx_a),
        .proto_err(err_a)
    );

    cbus_rr_arbiter #(.NUM_INPUTS(3), .ROUND_ROBIN(0)) dut_b (
        .clk(clk), .reset(reset), .ireqs(ireqs_b), .iresps(iresps_b),
        .oreq(oreq_b), .oresp(oresp), .busy(busy_b), .grant_idx(gidx_b),
        .proto_err(err_b)
    );

    // Behavioural model: owner of the bus, next priority start, sticky error.
    task automatic model_step(input int m, input int n, input bit rr, output exp_t e);
        int ptr, sel, g;
        e = '0;
        if (!reset) begin
            m_busy[m] = 0; m_owner[m] = 0; m_ptr[m] = 0; m_err[m] = 0;
        end
        ptr = rr ? m_ptr[m] : 0;
        sel = -1;
        for (int k = 0; k < n; k++) begin
            if (sel < 0 && ireqs_a[(ptr + k) % n].valid) sel = (ptr + k) % n;
        end
        g = (m_busy[m] != 0) ? m_owner[m] : sel;
        e.busy = (m_busy[m] != 0);
        e.err  = (m_err[m] != 0);
        if (g >= 0) begin
            e.gvalid    = ireqs_a[g].valid;
            e.gidx      = 2'(g);
            e.oreq      = ireqs_a[g];
            e.iresps[g] = oresp;
        end
        if (reset && g >= 0) begin
            if (oresp.last) begin
                m_busy[m] = 0;
                if (rr) m_ptr[m] = (g + 1) % n;
            end else if (m_busy[m] != 0) begin
                if (!ireqs_a[g].valid) m_err[m] = 1;
            end else begin
                m_busy[m]  = 1;
                m_owner[m] = g;
            end
        end
    endtask

    task automatic tick();
        exp_t ea, eb;
        @(posedge clk);
        #1;
        reset = stim_rst;
        for (int i = 0; i < 4; i++) ireqs_a[i] = stim_req[i];
        oresp = stim_resp;
        model_step(0, 4, 1'b1, ea);
        model_step(1, 3, 1'b0, eb);
        q_a.push_back(ea);
        q_b.push_back(eb);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q_a.size() != 0) begin
            e = q_a.pop_front();
            chk("a.busy", 64'(busy_a), 64'(e.busy));
            chk("a.proto_err", 64'(err_a), 64'(e.err));
            chk("a.oreq", 64'(oreq_a), 64'(e.oreq));
            for (int i = 0; i < 4; i++)
                chk($sformatf("a.iresps[%0d]", i), 64'(iresps_a[i]), 64'(e.iresps[i]));
            if (e.gvalid) chk("a.grant_idx", 64'(gidx_a), 64'(e.gidx));
        end
        if (q_b.size() != 0) begin
            e = q_b.pop_front();
            chk("b.busy", 64'(busy_b), 64'(e.busy));
            chk("b.proto_err", 64'(err_b), 64'(e.err));
            chk("b.oreq", 64'(oreq_b), 64'(e.oreq));
            for (int i = 0; i < 3; i++)
                chk($sformatf("b.iresps[%0d]", i), 64'(iresps_b[i]), 64'(e.iresps[i]));
            if (e.gvalid) chk("b.grant_idx", 64'(gidx_b), 64'(e.gidx));
        end
    end

    task automatic clear_stim();
        for (int i = 0; i < 4; i++) begin
            stim_req[i]       = '0;
            stim_req[i].addr  = 32'h1000_0000 + 32'(i) * 32'h100;
            stim_req[i].len   = 8'(i + 1);
            stim_req[i].write = i[0];
        end
        stim_resp      = '0;
        stim_resp.data = 32'hCAFE_0000;
    endtask

    task automatic do_reset();
        clear_stim();
        stim_rst = 1'b0;
        tick();
        stim_rst = 1'b1;
    endtask

    task automatic randomize_stim();
        for (int i = 0; i < 4; i++) begin
            if (stim_req[i].valid) begin
                if ($urandom_range(19) == 0) stim_req[i].valid = 1'b0;
                else if ($urandom_range(7) == 0) stim_req[i].addr = $urandom;
            end else if ($urandom_range(2) == 0) begin
                stim_req[i].valid = 1'b1;
                stim_req[i].write = 1'($urandom_range(1));
                stim_req[i].addr  = $urandom;
                stim_req[i].len   = 8'($urandom_range(1, 8));
            end
        end
        stim_resp.ready = 1'($urandom_range(1));
        stim_resp.last  = ($urandom_range(2) == 0);
        stim_resp.data  = $urandom;
        stim_rst        = ($urandom_range(149) != 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) ireqs_a[i] = '0;
        clear_stim();
        stim_rst = 1'b0;

        // reset held with input 1 requesting, then released
        stim_req[1].valid = 1'b1;
        tick();
        tick();
        stim_rst = 1'b1;
        tick();
        stim_resp.last = 1'b1;
        tick();

        // all inputs requesting, last every second cycle
        do_reset();
        for (int i = 0; i < 4; i++) stim_req[i].valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            stim_resp.last  = c[0];
            stim_resp.ready = 1'b1;
            stim_resp.data  = 32'hD000_0000 + 32'(c);
            tick();
        end

        // four-beat burst on input 1, input 0 arrives mid-burst
        do_reset();
        stim_req[1].valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) stim_req[0].valid = 1'b1;
            stim_resp.ready = 1'b1;
            stim_resp.last  = (c == 3);
            stim_resp.data  = 32'hB000_0000 + 32'(c);
            tick();
        end
        stim_req[1].valid = 1'b0;
        stim_resp.last = 1'b0;
        tick();
        stim_resp.last = 1'b1;
        tick();

        // zero-wait single beat on the highest input, then wrap check
        do_reset();
        stim_req[3].valid = 1'b1;
        stim_req[2].valid = 1'b1;
        stim_resp.last = 1'b1;
        tick();
        stim_req[0].valid = 1'b1;
        stim_resp.last = 1'b0;
        tick();
        tick();

        // protocol error: grant input 0, drop valid before last
        do_reset();
        stim_req[0].valid = 1'b1;
        tick();
        stim_req[0].valid = 1'b0;
        tick();
        tick();
        stim_resp.last = 1'b1;
        tick();
        stim_resp.last = 1'b0;
        stim_req[2].valid = 1'b1;
        tick();
        tick();
        do_reset();
        tick();

        // randomized traffic with occasional resets
        clear_stim();
        for (int c = 0; c < 3000; c++) begin
            randomize_stim();
            tick();
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain: pending %0d/%0d expected 0/0", q_a.size(), q_b.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
